// File: rtl/pdm_sample_sequencer.sv
// Sample-rate scheduler feeding the PDM modulator: FIFO in, one sample per tick out,
// with soft start/stop ramps when PDM_SEQ_RAMP_EN is defined (hard start/stop otherwise).
module pdm_sample_sequencer #(
  parameter int WIDTH      = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          rate_div,
  input  logic [WIDTH-1:0]              s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [WIDTH-1:0]              sample_out,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [WIDTH-1:0] MIDSCALE  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LW-1:0]    LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]    LVL_HALF  = LW'(FIFO_DEPTH / 2);

`ifdef PDM_SEQ_RAMP_EN
  typedef enum logic [2:0] {S_IDLE, S_RAMP_UP, S_FILL, S_PLAY, S_RAMP_DOWN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY} state_t;
`endif

  state_t               state_reg;
  logic [WIDTH-1:0]     sample_reg;
  logic [DIV_WIDTH-1:0] cnt_reg;
  logic                 tick_reg;

  logic [WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [LW-1:0]        level_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic flush;

  // Compare with >= so a rate_div lowered below the running count ticks at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (cnt_reg >= rate_div) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + DIV_WIDTH'(1);
      tick_reg <= 1'b0;
    end
  end

  assign full    = (level_reg == LVL_FULL);
  assign empty   = (level_reg == '0);
  assign s_ready = !reset && !full;
  assign push    = s_valid && s_ready;

  always_comb begin
    pop   = 1'b0;
    flush = 1'b0;
    case (state_reg)
      S_PLAY: begin
        pop = enable && tick_reg && !empty;
`ifndef PDM_SEQ_RAMP_EN
        flush = !enable;
`endif
      end
`ifdef PDM_SEQ_RAMP_EN
      S_RAMP_DOWN: flush = (sample_reg == '0) ||
                           (tick_reg && sample_reg == WIDTH'(1));
`else
      S_FILL: flush = !enable;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  // Flush wins over a same-cycle push so the FIFO is guaranteed empty in IDLE.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_reg + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      sample_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          sample_reg <= '0;
          if (enable) begin
`ifdef PDM_SEQ_RAMP_EN
            state_reg <= S_RAMP_UP;
`else
            state_reg  <= S_FILL;
            sample_reg <= MIDSCALE;
`endif
          end
        end
`ifdef PDM_SEQ_RAMP_EN
        S_RAMP_UP: begin
          if (!enable) begin
            state_reg <= S_RAMP_DOWN;
          end else if (tick_reg) begin
            if (sample_reg >= MIDSCALE - WIDTH'(1)) begin
              sample_reg <= MIDSCALE;
              state_reg  <= S_FILL;
            end else begin
              sample_reg <= sample_reg + WIDTH'(1);
            end
          end
        end
        S_RAMP_DOWN: begin
          if (sample_reg == '0) begin
            state_reg <= S_IDLE;
          end else if (tick_reg) begin
            sample_reg <= sample_reg - WIDTH'(1);
            if (sample_reg == WIDTH'(1)) state_reg <= S_IDLE;
          end
        end
`endif
        S_FILL: begin
          if (!enable) begin
`ifdef PDM_SEQ_RAMP_EN
            state_reg <= S_RAMP_DOWN;
`else
            state_reg  <= S_IDLE;
            sample_reg <= '0;
`endif
          end else if (level_reg >= LVL_HALF) begin
            state_reg <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!enable) begin
`ifdef PDM_SEQ_RAMP_EN
            state_reg <= S_RAMP_DOWN;
`else
            state_reg  <= S_IDLE;
            sample_reg <= '0;
`endif
          end else if (pop) begin
            sample_reg <= mem[rd_ptr_reg];
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          sample_reg <= '0;
        end
      endcase
    end
  end

  assign sample_out  = sample_reg;
  assign sample_tick = tick_reg;
  assign underrun    = (state_reg == S_PLAY) && tick_reg && empty;
  assign fifo_level  = level_reg;
  assign active      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// Self-checking bench for pdm_sample_sequencer: directed phases plus random traffic,
// every output compared each cycle against a queue-based reference model.
module tb_pdm_sample_sequencer;

  localparam int WIDTH     = 8;
  localparam int DIV_WIDTH = 16;
  localparam int DEPTH     = 8;
  localparam int MID       = 1 << (WIDTH - 1);

  localparam int M_IDLE = 0, M_UP = 1, M_FILL = 2, M_PLAY = 3, M_DOWN = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b0;
  logic [DIV_WIDTH-1:0] rate_div = '0;
  logic [WIDTH-1:0]     s_data = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [WIDTH-1:0]     sample_out;
  logic                 sample_tick;
  logic                 underrun;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                 active;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int               m_cnt = 0;
  bit               m_tick = 0;
  int               m_state = M_IDLE;
  int               m_out = 0;
  logic [WIDTH-1:0] m_q[$];
  bit               last_acc = 0;

  pdm_sample_sequencer #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rate_div(rate_div),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sample_out(sample_out), .sample_tick(sample_tick), .underrun(underrun),
    .fifo_level(fifo_level), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit push, pop, flush;
    int nstate, nout;
    if (reset) begin
      m_cnt = 0; m_tick = 0; m_state = M_IDLE; m_out = 0;
      m_q.delete(); last_acc = 0;
      return;
    end
    push = s_valid && (m_q.size() < DEPTH);
    pop = 0; flush = 0;
    nstate = m_state; nout = m_out;
    case (m_state)
      M_IDLE: begin
        nout = 0;
        if (enable) begin
`ifdef PDM_SEQ_RAMP_EN
          nstate = M_UP;
`else
          nstate = M_FILL; nout = MID;
`endif
        end
      end
      M_UP: begin
        if (!enable) nstate = M_DOWN;
        else if (m_tick) begin
          nout = (m_out + 1 > MID) ? MID : m_out + 1;
          if (nout == MID) nstate = M_FILL;
        end
      end
      M_DOWN: begin
        if (m_tick && m_out > 0) nout = m_out - 1;
        if (nout == 0) begin nstate = M_IDLE; flush = 1; end
      end
      M_FILL, M_PLAY: begin
        if (!enable) begin
`ifdef PDM_SEQ_RAMP_EN
          nstate = M_DOWN;
`else
          nstate = M_IDLE; nout = 0; flush = 1;
`endif
        end else if (m_state == M_FILL) begin
          if (m_q.size() >= DEPTH / 2) nstate = M_PLAY;
        end else if (m_tick && m_q.size() > 0) begin
          nout = int'(m_q[0]); pop = 1;
        end
      end
      default: ;
    endcase
    // One tick per (rate_div + 1) cycles, reloading as soon as the count reaches rate_div.
    if (m_cnt >= int'(rate_div)) begin m_tick = 1; m_cnt = 0; end
    else begin m_tick = 0; m_cnt++; end
    if (pop)   void'(m_q.pop_front());
    if (push)  m_q.push_back(s_data);
    if (flush) m_q.delete();
    last_acc = push;
    m_state = nstate;
    m_out = nout;
  endtask

  task automatic cycle();
    @(negedge clk);
    check("sample_out", 32'(sample_out), 32'(m_out));
    check("sample_tick", 32'(sample_tick), 32'(m_tick));
    check("underrun", 32'(underrun), 32'(m_state == M_PLAY && m_tick && m_q.size() == 0));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("s_ready", 32'(s_ready), 32'(!reset && m_q.size() < DEPTH));
    check("active", 32'(active), 32'(m_state != M_IDLE));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input string tag, input int target, input int max_cycles);
    int n = 0;
    while (m_state != target && n < max_cycles) begin
      cycle();
      n++;
    end
    check(tag, 32'(m_state), 32'(target));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and ramp to midscale with no data
    reset = 1; rate_div = 16'd3;
    repeat (3) cycle();
    reset = 0; enable = 1;
    run_until("reach_fill", M_FILL, 1000);
    repeat (10) cycle();
    check("fill_midscale", 32'(sample_out), 32'(MID));
    check("fill_active", 32'(active), 32'd1);

    // Four beats start playback, then an underrun holds the last sample
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = 8'(8'h10 + i);
      cycle();
    end
    s_valid = 0;
    repeat (40) cycle();
    check("hold_after_underrun", 32'(sample_out), 32'h13);

    // Overfill with a slow rate: 8 accepted, 9th held
    rate_div = 16'd200;
    s_valid = 1; s_data = 8'h20;
    repeat (12) begin
      cycle();
      if (last_acc) s_data = s_data + 8'd1;
    end
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    check("full_ready", 32'(s_ready), 32'd0);
    check("held_beat", 32'(s_data), 32'h28);
    s_valid = 0;

    // Shutdown with enable re-asserted mid-ramp
    rate_div = 16'd1; enable = 0;
    repeat (10) cycle();
    enable = 1;
    run_until("back_to_idle", M_IDLE, 400);
    check("idle_level", 32'(fifo_level), 32'd0);
`ifdef PDM_SEQ_RAMP_EN
    run_until("restart_ramp", M_UP, 10);
`else
    run_until("restart_fill", M_FILL, 10);
`endif

    // Reset mid-ramp with data queued
    rate_div = 16'd0;
    s_valid = 1; s_data = 8'h55;
    repeat (3) cycle();
    s_valid = 0;
`ifdef PDM_SEQ_RAMP_EN
    while (m_out < 60 && m_state == M_UP) cycle();
`else
    repeat (5) cycle();
`endif
    reset = 1; enable = 0;
    cycle();
    reset = 0;
    check("reset_abort_out", 32'(sample_out), 32'd0);
    check("reset_abort_level", 32'(fifo_level), 32'd0);
    check("reset_abort_active", 32'(active), 32'd0);
    enable = 1;
    repeat (3) cycle();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rate_div = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) enable = !enable;
      reset = ($urandom_range(0, 999) == 0);
      if (!s_valid || last_acc) begin
        s_valid = ($urandom_range(0, 1) == 1);
        s_data = 8'($urandom);
      end
      cycle();
    end
    reset = 0;
    s_valid = 0;
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
